reg_swap_ctrl: RTL and testbench

Parametrised register-file swap controller: holds NREGS registers of WIDTH bits and exchanges the contents of any two of them through a temporary register over a shared internal bus, in a three-transfer sequence with a start/done handshake. It generalises our fixed three-register swap FSM in the following ways:
- arbitrary register count and width;
- runtime-selected source pair;
- host load/read access;
- out-of-range detection.

It sits between the datapath register bank and the sequencing control.

---
 rtl/reg_swap_ctrl_if.sv | 27 ++
 rtl/reg_swap_ctrl.sv | 71 +++++++
 tb/tb_reg_swap_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_swap_ctrl_if.sv
// reg_swap_ctrl_if: swap-controller bus; master drives start/src/ld/rd_idx, slave returns rd_data/y/busy/done/err
interface reg_swap_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int IDXW = (NREGS > 2) ? $clog2(NREGS) : 1;
  logic             i_start;
  logic [IDXW-1:0]  i_src_a;
  logic [IDXW-1:0]  i_src_b;
  logic             i_ld_en;
  logic [IDXW-1:0]  i_ld_idx;
  logic [WIDTH-1:0] i_ld_data;
  logic [IDXW-1:0]  i_rd_idx;
  logic [WIDTH-1:0] o_rd_data;
  logic [1:0]       o_y;
  logic             o_busy;
  logic             o_done;
  logic             o_err;
  modport master (
    output i_start, i_src_a, i_src_b, i_ld_en, i_ld_idx, i_ld_data, i_rd_idx,
    input  o_rd_data, o_y, o_busy, o_done, o_err
  );
  modport slave (
    input  i_start, i_src_a, i_src_b, i_ld_en, i_ld_idx, i_ld_data, i_rd_idx,
    output o_rd_data, o_y, o_busy, o_done, o_err
  );
endinterface

// File: rtl/reg_swap_ctrl.sv
// reg_swap_ctrl: swaps two of NREGS registers through tmp in 3 transfers; ports clk, rst, bus (start/src/ld/rd_idx in, rd_data/y/busy/done/err out)
module reg_swap_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic            clk,
  input logic            rst,
  reg_swap_ctrl_if.slave bus
);
  localparam int IDXW = (NREGS > 2) ? $clog2(NREGS) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, T1 = 2'b01, T2 = 2'b11, T3 = 2'b10} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_tmp;
  logic [IDXW-1:0]  r_a;
  logic [IDXW-1:0]  r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_start_ok;
  function automatic logic in_range(input logic [IDXW-1:0] idx);
    return 32'(idx) < 32'(NREGS);
  endfunction
  assign w_start_ok    = in_range(bus.i_src_a) && in_range(bus.i_src_b);
  assign bus.o_rd_data = in_range(bus.i_rd_idx) ? r_regs[bus.i_rd_idx] : '0;
  assign bus.o_y       = r_state;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_err     = r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tmp   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= (i == 0) ? WIDTH'(1) : '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_ld_en && in_range(bus.i_ld_idx)) r_regs[bus.i_ld_idx] <= bus.i_ld_data;
          if (bus.i_start && w_start_ok) begin
            r_a     <= bus.i_src_a;
            r_b     <= bus.i_src_b;
            r_state <= T1;
            r_busy  <= 1'b1;
          end
          r_err <= bus.i_start && !w_start_ok;
        end
        T1: begin
          r_tmp   <= r_regs[r_b];
          r_state <= T2;
        end
        T2: begin
          r_regs[r_b] <= r_regs[r_a];
          r_state     <= T3;
        end
        default: begin
          r_regs[r_a] <= r_tmp;
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_swap_ctrl.sv
// tb_reg_swap_ctrl: directed plus randomized checks of reg_swap_ctrl against an array model of the register file
module tb_reg_swap_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  reg_swap_ctrl_if #(.WIDTH(8), .NREGS(4)) bus ();
  reg_swap_ctrl_if #(.WIDTH(8), .NREGS(5)) bus5 ();
  reg_swap_ctrl #(.WIDTH(8), .NREGS(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  reg_swap_ctrl #(.WIDTH(8), .NREGS(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] m [4];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      bus.i_rd_idx = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(bus.o_rd_data), 32'(m[i]));
    end
  endtask
  task automatic chk_regs5(input string tag, input logic [7:0] e0, input logic [7:0] e4);
    for (int i = 0; i < 8; i++) begin
      bus5.i_rd_idx = 3'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(bus5.o_rd_data), (i == 0) ? 32'(e0) : (i == 4) ? 32'(e4) : 32'd0);
    end
  endtask
  task automatic load(input int idx, input logic [7:0] d);
    bus.i_ld_en   = 1'b1;
    bus.i_ld_idx  = 2'(idx);
    bus.i_ld_data = d;
    @(posedge clk);
    #1;
    bus.i_ld_en = 1'b0;
    m[idx] = d;
  endtask
  task automatic do_swap(input int a, input int b, input bit wl, input int li, input logic [7:0] ld);
    logic [7:0] t;
    bus.i_start   = 1'b1;
    bus.i_src_a   = 2'(a);
    bus.i_src_b   = 2'(b);
    bus.i_ld_en   = wl;
    bus.i_ld_idx  = 2'(li);
    bus.i_ld_data = ld;
    @(posedge clk);
    #1;
    if (wl) m[li] = ld;
    bus.i_start = 1'b0;
    bus.i_ld_en = 1'b0;
    bus.i_src_a = 2'($urandom);
    bus.i_src_b = 2'($urandom);
    chk("y_t1", 32'(bus.o_y), 1);
    chk("busy_t1", 32'(bus.o_busy), 1);
    @(posedge clk);
    #1;
    chk("y_t2", 32'(bus.o_y), 3);
    @(posedge clk);
    #1;
    chk("y_t3", 32'(bus.o_y), 2);
    chk("done_t3", 32'(bus.o_done), 0);
    @(posedge clk);
    #1;
    chk("y_end", 32'(bus.o_y), 0);
    chk("busy_end", 32'(bus.o_busy), 0);
    chk("done_pulse", 32'(bus.o_done), 1);
    t = m[a];
    m[a] = m[b];
    m[b] = t;
    chk_regs("swap");
    @(posedge clk);
    #1;
    chk("done_clear", 32'(bus.o_done), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_src_a = '0;
    bus.i_src_b = '0;
    bus.i_ld_en = 1'b0;
    bus.i_ld_idx = '0;
    bus.i_ld_data = '0;
    bus.i_rd_idx = '0;
    bus5.i_start = 1'b0;
    bus5.i_src_a = '0;
    bus5.i_src_b = '0;
    bus5.i_ld_en = 1'b0;
    bus5.i_ld_idx = '0;
    bus5.i_ld_data = '0;
    bus5.i_rd_idx = '0;
    m = '{8'h01, 8'h00, 8'h00, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_y", 32'(bus.o_y), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    chk_regs("rst");
    load(1, 8'hA5);
    load(3, 8'h3C);
    do_swap(1, 3, 1'b0, 0, 8'h00);
    load(2, 8'h77);
    do_swap(2, 2, 1'b0, 0, 8'h00);
    bus5.i_start = 1'b1;
    bus5.i_src_a = 3'd4;
    bus5.i_src_b = 3'd5;
    @(posedge clk);
    #1;
    bus5.i_start = 1'b0;
    chk("err_pulse", 32'(bus5.o_err), 1);
    chk("err_y", 32'(bus5.o_y), 0);
    chk("err_busy", 32'(bus5.o_busy), 0);
    @(posedge clk);
    #1;
    chk("err_clear", 32'(bus5.o_err), 0);
    chk("err_nodone", 32'(bus5.o_done), 0);
    bus5.i_start = 1'b1;
    bus5.i_src_a = 3'd1;
    bus5.i_src_b = 3'd7;
    @(posedge clk);
    #1;
    bus5.i_start = 1'b0;
    chk("err_b_pulse", 32'(bus5.o_err), 1);
    bus5.i_ld_en = 1'b1;
    bus5.i_ld_idx = 3'd6;
    bus5.i_ld_data = 8'h5A;
    @(posedge clk);
    #1;
    bus5.i_ld_en = 1'b0;
    chk("ld_oor_noerr", 32'(bus5.o_err), 0);
    chk_regs5("oor", 8'h01, 8'h00);
    bus5.i_start = 1'b1;
    bus5.i_src_a = 3'd0;
    bus5.i_src_b = 3'd4;
    @(posedge clk);
    #1;
    bus5.i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("n5_done", 32'(bus5.o_done), 1);
    chk_regs5("n5_swap", 8'h00, 8'h01);
    bus.i_start = 1'b1;
    bus.i_src_a = 2'd0;
    bus.i_src_b = 2'd2;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(posedge clk);
    #1;
    chk("ign_y_t2", 32'(bus.o_y), 3);
    bus.i_start = 1'b1;
    bus.i_src_a = 2'd1;
    bus.i_src_b = 2'd3;
    bus.i_ld_en = 1'b1;
    bus.i_ld_idx = 2'd0;
    bus.i_ld_data = 8'hFF;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_ld_en = 1'b0;
    chk("ign_y_t3", 32'(bus.o_y), 2);
    @(posedge clk);
    #1;
    chk("ign_done", 32'(bus.o_done), 1);
    begin
      logic [7:0] t;
      t = m[0];
      m[0] = m[2];
      m[2] = t;
    end
    chk_regs("ign");
    @(posedge clk);
    #1;
    chk("ign_no_restart", 32'(bus.o_y), 0);
    bus.i_start = 1'b1;
    bus.i_src_a = 2'd1;
    bus.i_src_b = 2'd3;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    m = '{8'h01, 8'h00, 8'h00, 8'h00};
    chk("arst_y", 32'(bus.o_y), 0);
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_done", 32'(bus.o_done), 0);
    chk_regs("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("arst_nodone", 32'(bus.o_done), 0);
    end
    load(1, 8'h11);
    do_swap(1, 3, 1'b0, 0, 8'h00);
    for (int k = 0; k < 15; k++) begin
      int a, b, li;
      bit wl;
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      li = int'($urandom_range(0, 3));
      wl = 1'($urandom);
      if ($urandom_range(0, 1) == 1) load(int'($urandom_range(0, 3)), 8'($urandom));
      do_swap(a, b, wl, li, 8'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
